aes_decipher_ctrl: RTL
======================

# aes_decipher_ctrl

Sequencer and state holder for AES decryption. It accepts a 128-bit ciphertext block and drives the combinational decipher round datapath one round per cycle: the init round, then Nr-1 main rounds, then the final round. It fetches round keys from the key memory in descending order and registers the recovered plaintext. It sits between the core's block and key-memory interfaces (upstream) and the decipher round logic (downstream).

## Interface
Parameters:
- AES_128_NR, 10, number of rounds for 128-bit keys.
- AES_256_NR, 14, number of rounds for 256-bit keys.

Ports:
- clk  in  1  core clock; single clock domain.
- reset_n  in  1  reset, synchronous, active-low.
- next  in  1  start pulse; accepted only when ready=1.
- keylen  in  1  0 selects AES-128 (Nr=10), 1 selects AES-256 (Nr=14); sampled with next.
- block  in  128  ciphertext; sampled with next. Byte order is column-major: [127:120]=s00, [119:112]=s10, [111:104]=s20, [103:96]=s30, [95:88]=s01, and so on.
- round_nr  out  4  key-memory index of the round key needed this cycle.
- round_key  in  128  key for round_nr; combinational from key memory, same cycle.
- rnd_type  out  2  to round datapath: 0=INIT, 1=MAIN, 2=FINAL.
- rnd_key  out  128  round_key passed through unchanged.
- rnd_state  out  128  current state register, same byte order as block.
- rnd_state_new  in  128  round datapath result for rnd_state/rnd_type/rnd_key.
- ready  out  1  idle and able to accept next.
- result  out  128  plaintext register.
- result_valid  out  1  result holds the plaintext of the last completed operation.

## Operation
- FSM states and transitions:
  - IDLE: next=1 → INIT.
  - INIT → MAIN, or → FINAL if Nr-1=0 (never occurs for legal Nr, but it is the required transition).
  - MAIN → FINAL when round_nr=1 at the clock edge.
  - FINAL → IDLE.
- Accepting next in IDLE, at that edge:
  - state_reg ← block.
  - round counter ← Nr, selected by keylen.
  - ready ← 0, result_valid ← 0.
- INIT: rnd_type=0, round_nr=Nr; at the edge, state_reg ← rnd_state_new, counter ← Nr-1.
- MAIN: rnd_type=1, round_nr=counter; at each edge, state_reg ← rnd_state_new, counter decrements. Lasts Nr-1 cycles: keys Nr-1 down to 1.
- FINAL: rnd_type=2, round_nr=0; at the edge:
  - result ← rnd_state_new.
  - result_valid ← 1, ready ← 1.
  - counter ← 0.
- IDLE: rnd_type=0, round_nr=0, state_reg holds its value.
- rnd_key = round_key in all states (combinational).
- Counter is 4 bits wide; it never wraps (minimum value 0, only reached in FINAL/IDLE).
- keylen and block changing mid-operation have no effect; only the values sampled at accept are used.

## Timing
- Reset values (synchronous, on the clk edge with reset_n=0):
  - FSM=IDLE, ready=1, result_valid=0.
  - result=0, state_reg=0 (rnd_state=0).
  - counter=0, so round_nr=0 and rnd_type=0.
- Latency: next accepted at edge E0 → result_valid=1 and ready=1 after edge E0+Nr+1. That is 11 cycles for AES-128 and 15 for AES-256.
- ready is low from E0+1 through E0+Nr+1 exclusive: exactly Nr+1 busy cycles.
- next while ready=0: ignored, no state change.
- next in the same cycle that FINAL completes: ignored (ready is still 0 in that cycle).
- Back-to-back: next asserted in the first cycle ready=1 is accepted. result_valid drops to 0 at that edge; result keeps its old value until the next FINAL.
- reset_n=0 mid-operation: the block aborts at that edge and all outputs take their reset values. result from the previous operation is lost.
- result and result_valid are registered; round_nr, rnd_type and rnd_key are combinational from registers and round_key.

## Test plan
- AES-128, FIPS-197 C.1: key 000102…0f, block 69c4e0d86a7b0430d8cdb78070b4c55a, bench key-memory and round models → result 00112233445566778899aabbccddeeff, result_valid high exactly 11 cycles after next.
- AES-256, FIPS-197 C.3: key 000102…1f, block 8ea2b7ca516745bfeafc49904b496089 → result 00112233445566778899aabbccddeeff after 15 cycles. Over the operation, round_nr sequence is 14,13,…,1,0 and rnd_type is 0, then 1×13, then 2.
- Busy next: pulse next at cycles 3 and 10 of an AES-128 operation with a different block → ignored; result is unchanged from the C.1 plaintext.
- Reset mid-op: assert reset_n=0 at cycle 5 → next edge gives ready=1, result_valid=0, result=0, round_nr=0. A fresh C.1 run afterwards completes correctly.
- Back-to-back: second next in the first ready cycle with the C.3 block and keylen=1 → result_valid falls at accept, old result is held, and the new result is valid 15 cycles later.

Source files
------------

// File: rtl/aes_decipher_ctrl.sv
// aes_decipher_ctrl
// Sequencer and state holder for AES decryption. It walks the external
// combinational decipher round datapath through one INIT round, Nr-1 MAIN
// rounds and one FINAL round, one round per clock. Round keys are requested
// from the key memory in descending order (Nr down to 0). The recovered
// plaintext is registered in result.

module aes_decipher_ctrl #(
    parameter int unsigned AES_128_NR = 10,
    parameter int unsigned AES_256_NR = 14
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [3:0]   round_nr,
    input  logic [127:0] round_key,
    output logic [1:0]   rnd_type,
    output logic [127:0] rnd_key,
    output logic [127:0] rnd_state,
    input  logic [127:0] rnd_state_new,
    output logic         ready,
    output logic [127:0] result,
    output logic         result_valid
);

    // Round counts narrowed to the counter width once, here.
    localparam logic [3:0] NR_128 = 4'(AES_128_NR);
    localparam logic [3:0] NR_256 = 4'(AES_256_NR);

    // Encoding of rnd_type as seen by the round datapath.
    localparam logic [1:0] RND_INIT  = 2'd0;
    localparam logic [1:0] RND_MAIN  = 2'd1;
    localparam logic [1:0] RND_FINAL = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_MAIN,
        S_FINAL
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic [127:0] result_q, result_d;

    // State register: synchronous active-low reset clears every flop,
    // including the previous result.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of the
        // order of statements or blocks.
        if (!reset_n) begin
            fsm_q    <= S_IDLE;
            state_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    // Next-state and round-control decode for the current FSM state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so that no
        // path through the case statement can leave one unassigned and
        // infer a latch.
        fsm_d    = fsm_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        result_d = result_q;
        round_nr = 4'd0;
        rnd_type = RND_INIT;

        unique case (fsm_q)
            S_IDLE: begin
                // block and keylen are only looked at here, so changes
                // during an operation have no effect.
                if (next) begin
                    state_d = block;
                    cnt_d   = keylen ? NR_256 : NR_128;
                    ready_d = 1'b0;
                    valid_d = 1'b0;
                    fsm_d   = S_INIT;
                end
            end

            S_INIT: begin
                rnd_type = RND_INIT;
                round_nr = cnt_q;
                state_d  = rnd_state_new;
                cnt_d    = cnt_q - 4'd1;
                fsm_d    = (cnt_q == 4'd1) ? S_FINAL : S_MAIN;
            end

            S_MAIN: begin
                // Keys Nr-1 down to 1; leave after the round using key 1.
                rnd_type = RND_MAIN;
                round_nr = cnt_q;
                state_d  = rnd_state_new;
                cnt_d    = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    fsm_d = S_FINAL;
                end
            end

            S_FINAL: begin
                // Key 0; the datapath output is the plaintext.
                rnd_type = RND_FINAL;
                round_nr = 4'd0;
                result_d = rnd_state_new;
                valid_d  = 1'b1;
                ready_d  = 1'b1;
                cnt_d    = 4'd0;
                fsm_d    = S_IDLE;
            end

            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // Datapath-facing and core-facing outputs.
    assign rnd_key      = round_key;
    assign rnd_state    = state_q;
    assign ready        = ready_q;
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule
